// File: rtl/stream_arb_mux_if.sv
// stream_arb_mux_if: multi-channel input streams plus one arbitrated output stream.
interface stream_arb_mux_if #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
   logic [CHANNELS*WIDTH-1:0] in_bus;
   logic [CHANNELS-1:0]       in_valid;
   logic [CHANNELS-1:0]       in_last;
   logic [CHANNELS-1:0]       in_ready;
   logic [WIDTH-1:0]          out;
   logic                      out_valid;
   logic                      out_last;
   logic [SEL_W-1:0]          out_sel;
   logic                      out_ready;
   modport master (output in_bus, in_valid, in_last, out_ready,
                   input  in_ready, out, out_valid, out_last, out_sel);
   modport slave  (input  in_bus, in_valid, in_last, out_ready,
                   output in_ready, out, out_valid, out_last, out_sel);
endinterface

// File: rtl/stream_arb_mux.sv
// stream_arb_mux: packet-aware N:1 stream mux with round-robin or fixed-priority arbitration.
module stream_arb_mux #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int RR       = 1
) (
   input logic              clk,
   input logic              rst,
   stream_arb_mux_if.slave  bus
);
   localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   typedef enum logic {IDLE, LOCKED} state_t;
   state_t state, next_state;
   logic [SEL_W-1:0] lock_ch, rr_ptr, win, grant_ch;
   logic found, grant_vld, load, xfer, last;
   logic [WIDTH-1:0] data;
   int idx;
   always_comb begin
      win = '0;
      found = 1'b0;
      idx = 0;
      // descending scan so the nearest channel to the search origin wins
      for (int k = CHANNELS - 1; k >= 0; k--) begin
         idx = (RR != 0) ? (int'(rr_ptr) + k) % CHANNELS : k;
         if (bus.in_valid[idx]) begin
            win = SEL_W'(idx);
            found = 1'b1;
         end
      end
   end
   assign grant_ch  = (state == LOCKED) ? lock_ch : win;
   assign grant_vld = (state == LOCKED) || found;
   assign load      = !bus.out_valid || bus.out_ready;
   assign xfer      = |(bus.in_valid & bus.in_ready);
   assign last      = bus.in_last[grant_ch];
   assign data      = bus.in_bus[grant_ch*WIDTH +: WIDTH];
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= next_state;
   always_comb begin
      next_state = state;
      if (xfer) next_state = last ? IDLE : LOCKED;
   end
   always_comb begin
      bus.in_ready = '0;
      if (!rst && grant_vld && load) bus.in_ready = CHANNELS'(1) << grant_ch;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bus.out       <= '0;
         bus.out_valid <= 1'b0;
         bus.out_last  <= 1'b0;
         bus.out_sel   <= '0;
         lock_ch       <= '0;
         rr_ptr        <= '0;
      end else begin
         if (load) bus.out_valid <= xfer;
         if (xfer) begin
            bus.out      <= data;
            bus.out_last <= last;
            bus.out_sel  <= grant_ch;
         end
         if (xfer && !last && state == IDLE) lock_ch <= grant_ch;
         if (RR != 0 && xfer && last)
            rr_ptr <= (grant_ch == SEL_W'(CHANNELS - 1)) ? '0 : grant_ch + 1'b1;
      end
endmodule

// File: tb/tb_stream_arb_mux.sv
// tb_stream_arb_mux: directed checks of a round-robin and a fixed-priority stream_arb_mux.
module tb_stream_arb_mux;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int passed = 0;
   always #5 clk = ~clk;
   stream_arb_mux_if #(.WIDTH(8), .CHANNELS(4)) ia();
   stream_arb_mux_if #(.WIDTH(8), .CHANNELS(4)) ib();
   stream_arb_mux #(.WIDTH(8), .CHANNELS(4), .RR(1)) dut_rr (.clk(clk), .rst(rst), .bus(ia));
   stream_arb_mux #(.WIDTH(8), .CHANNELS(4), .RR(0)) dut_fp (.clk(clk), .rst(rst), .bus(ib));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   initial begin
      ia.in_bus = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      ia.in_valid = 4'hF;
      ia.in_last = 4'hF;
      ia.out_ready = 1'b1;
      ib.in_bus = '0;
      ib.in_valid = '0;
      ib.in_last = '0;
      ib.out_ready = 1'b1;
      tick();
      tick();
      check("rst_valid", ia.out_valid, 0);
      check("rst_out", ia.out, 0);
      check("rst_sel", ia.out_sel, 0);
      check("rst_ready", ia.in_ready, 0);
      rst = 1'b0;
      #1;
      check("rr_first_ready", ia.in_ready, 4'b0001);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("rr_sel", ia.out_sel, k % 4);
         check("rr_data", ia.out, 8'hA0 + k % 4);
         check("rr_valid", ia.out_valid, 1);
      end
      ia.in_valid = '0;
      for (int k = 0; k < 2; k++) begin
         tick();
         check("gap_valid", ia.out_valid, 0);
         check("gap_hold", ia.out, 8'hA0);
      end
      ia.in_valid = 4'b0011;
      ia.in_last = 4'b0001;
      ia.in_bus = {8'h00, 8'h00, 8'hB1, 8'h55};
      #1;
      check("lock_grant", ia.in_ready, 4'b0010);
      tick();
      check("lock_w1", ia.out, 8'hB1);
      check("lock_w1_sel", ia.out_sel, 1);
      check("lock_w1_last", ia.out_last, 0);
      ia.in_bus[15:8] = 8'hB2;
      tick();
      check("lock_w2", ia.out, 8'hB2);
      check("lock_w2_valid", ia.out_valid, 1);
      ia.in_bus[15:8] = 8'hB3;
      ia.in_last = 4'b0011;
      tick();
      check("lock_w3", ia.out, 8'hB3);
      check("lock_w3_last", ia.out_last, 1);
      ia.in_valid = 4'b0001;
      #1;
      check("next_grant", ia.in_ready, 4'b0001);
      tick();
      check("ch0_after", ia.out, 8'h55);
      check("ch0_sel", ia.out_sel, 0);
      ia.out_ready = 1'b0;
      ia.in_bus[7:0] = 8'h66;
      #1;
      check("bp_ready", ia.in_ready, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("bp_hold", ia.out, 8'h55);
         check("bp_valid", ia.out_valid, 1);
         check("bp_ready_hold", ia.in_ready, 0);
      end
      ia.out_ready = 1'b1;
      #1;
      check("bp_release", ia.in_ready, 4'b0001);
      tick();
      check("bp_next", ia.out, 8'h66);
      ia.in_valid = '0;
      tick();
      check("bp_once", ia.out_valid, 0);
      check("bp_once_hold", ia.out, 8'h66);
      ia.in_valid = 4'b0100;
      ia.in_last = 4'b0000;
      ia.in_bus = {8'h00, 8'hC1, 8'h00, 8'h77};
      tick();
      check("mid_w1", ia.out, 8'hC1);
      check("mid_sel", ia.out_sel, 2);
      ia.in_valid = 4'b0001;
      ia.in_last = 4'b0001;
      #1;
      check("mid_locked", ia.in_ready, 4'b0100);
      rst = 1'b1;
      #1;
      check("arst_valid", ia.out_valid, 0);
      check("arst_ready", ia.in_ready, 0);
      check("arst_out", ia.out, 0);
      rst = 1'b0;
      ia.in_valid = 4'hF;
      ia.in_last = 4'hF;
      #1;
      check("post_rst_grant", ia.in_ready, 4'b0001);
      tick();
      check("post_rst_sel", ia.out_sel, 0);
      check("post_rst_valid", ia.out_valid, 1);
      ia.in_valid = '0;
      ib.in_valid = 4'b0101;
      ib.in_last = 4'hF;
      ib.in_bus = {8'h00, 8'h12, 8'h00, 8'h10};
      #1;
      check("fp_ready", ib.in_ready, 4'b0001);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("fp_sel", ib.out_sel, 0);
         check("fp_data", ib.out, 8'h10);
         check("fp_starve", ib.in_ready, 4'b0001);
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
